sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Synchronous single-clock FIFO that buffers N-bit words between a producer and the team's enable/clear capture register.
- The consumer's read strobe, rd_valid, drives the register's enable, and rd_data drives its data.
- It uses the same clk, reset and clear semantics as the rest of the register datapath: async active-low reset, sync clear.
- It absorbs bursts from upstream and reports over/underflow as sticky error flags.

Parameters:
N, 100, data word width in bits (matches the downstream register width)
DEPTH, 16, number of storage entries; must be a power of two, >= 2
AW, $clog2(DEPTH), derived pointer width; not to be overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
clear  input  1  synchronous clear; empties FIFO, clears flags
wr_en  input  1  write request
wr_data  input  N  write data
full  output  1  FIFO holds DEPTH words
rd_en  input  1  read request
rd_data  output  N  registered read data
rd_valid  output  1  rd_data updated this cycle (one-cycle pulse per accepted read)
empty  output  1  FIFO holds 0 words
count  output  AW+1  number of stored words, 0..DEPTH
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and count go to 0.
  - rd_data={N{1'b0}}; rd_valid=0, overflow=0, underflow=0.
  - full=0, empty=1.
  - Memory contents are don't-care.
- clear=1 at a rising edge: identical effect to reset, synchronous. Takes priority over wr_en and rd_en in the same cycle; neither is accepted and neither error flag is set.
- Write accept: wr_acc = wr_en & (~full | rd_en).
  - A write when full is accepted only with a simultaneous accepted read.
  - Accepted data is stored at mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Read accept: rd_acc = rd_en & ~empty.
  - On an accepted read, rd_data <= mem[rd_ptr] at the same edge, so latency is 1 cycle from the rd_en edge.
  - rd_valid=1 for exactly that following cycle; rd_ptr increments modulo DEPTH.
  - With no accepted read, rd_data holds its value and rd_valid=0.
- Empty, with wr_en and rd_en asserted together: the write is accepted, the read is rejected, underflow is set. There is no fall-through.
- Full, with wr_en and rd_en asserted together: both are accepted; count stays at DEPTH; the read returns the oldest word.
- Dropped write (wr_en & full & ~rd_en): data is discarded, state is unchanged, overflow <= 1.
- Rejected read (rd_en & empty): rd_data is unchanged, rd_valid=0, underflow <= 1.
- Sticky flags: overflow and underflow clear only on reset or clear.
- count update: count <= count + wr_acc - rd_acc.
  - full = (count==DEPTH) and empty = (count==0); both are registered/derived from count and always consistent with it.
- Pointer wrap-around is a natural AW-bit rollover. Ordering is strict FIFO across any number of wraps.
- Reset asserted mid-burst: state is lost immediately; the first write after release is stored at entry 0.
- No combinational path from inputs to outputs; all outputs are registers or decode of registers.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- Write 0x01..0x10 (16 words, N=100, DEPTH=16) -> full=1, count=16. Then 16 reads -> rd_valid pulses carry 0x01..0x10 in order, one cycle after each rd_en. Final state empty=1, count=0.
- Full FIFO, wr_en=1 with data 0xAA, rd_en=0 -> count stays 16, overflow=1. Draining the FIFO never returns 0xAA.
- Full FIFO, wr_en & rd_en for 20 cycles writing 0x100+i -> count stays 16, reads return the old contents then 0x100.., overflow=0. This covers pointer wrap.
- Empty FIFO, wr_en & rd_en together with 0x55 -> rd_valid=0, underflow=1, count=1. A later read returns 0x55.
- 5 words stored, clear=1 with wr_en=1 and rd_en=1 -> next cycle count=0, empty=1, rd_data=0, rd_valid=0, flags 0. Async reset pulse asserted mid-write likewise forces all outputs to reset values without a clock edge.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO feeding the enable/clear capture register: registered read
// port, count-derived full/empty, sticky overflow/underflow error flags.
module sync_fifo #(
  parameter  int unsigned N     = 100,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [N-1:0]  wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_rd_data;
  logic          r_rd_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_wr_drop;
  logic          w_rd_rej;
  logic [CW-1:0] w_count_nxt;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Clear wins over both requests, so it gates every accept and error term.
  always_comb begin
    w_rd_acc    = ~clear & rd_en & ~w_empty;
    w_wr_acc    = ~clear & wr_en & (~w_full | rd_en);
    w_wr_drop   = ~clear & wr_en & w_full & ~rd_en;
    w_rd_rej    = ~clear & rd_en & w_empty;
    w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
  end

  // Storage carries no reset; when full with a simultaneous read, the read
  // below samples the old word before this write lands in the same slot.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_wr_drop) r_overflow  <= 1'b1;
      if (w_rd_rej)  r_underflow <= 1'b1;
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (N=100, DEPTH=16): hand-computed expectations
// for fill/drain order, overflow, wrap, underflow, clear and async reset.
module tb_sync_fifo;

  localparam int unsigned W = 100;
  localparam int unsigned D = 16;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          full;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int unsigned n_vec;
  int unsigned n_err;

  sync_fifo #(.N(W), .DEPTH(D)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs set before tick() are sampled at the next rising edge; checks
  // happen 1ns after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, ".empty"},     W'(empty),     W'(1));
    check({tag, ".full"},      W'(full),      W'(0));
    check({tag, ".count"},     W'(count),     W'(0));
    check({tag, ".rd_valid"},  W'(rd_valid),  W'(0));
    check({tag, ".rd_data"},   rd_data,       '0);
    check({tag, ".overflow"},  W'(overflow),  W'(0));
    check({tag, ".underflow"}, W'(underflow), W'(0));
  endtask

  task automatic fill16(input logic [W-1:0] base);
    wr_en = 1'b1;
    rd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_data = base + W'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain16(input string tag, input logic [W-1:0] base);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check({tag, ".valid"}, W'(rd_valid), W'(1));
      check({tag, ".data"},  rd_data,      base + W'(i));
    end
    rd_en = 1'b0;
    tick();
    check({tag, ".valid_end"}, W'(rd_valid), W'(0));
    check({tag, ".empty"},     W'(empty),    W'(1));
    check({tag, ".count"},     W'(count),    W'(0));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();
    check_idle_state("reset");

    // Fill 0x01..0x10, then drain in order
    fill16(W'('h01));
    check("fill.full",  W'(full),  W'(1));
    check("fill.count", W'(count), W'(16));
    drain16("drain1", W'('h01));

    // Dropped write while full: 0xAA never comes out
    fill16(W'('h200));
    wr_en   = 1'b1;
    wr_data = W'('hAA);
    tick();
    wr_en = 1'b0;
    check("ovf.count", W'(count),    W'(16));
    check("ovf.flag",  W'(overflow), W'(1));
    drain16("drain_ovf", W'('h200));
    check("ovf.sticky", W'(overflow), W'(1));

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_state("clear1");

    // Full with simultaneous write+read for 20 cycles, across pointer wrap
    fill16(W'('h300));
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = W'('h100) + W'(i);
      tick();
      check("wrap.count", W'(count),    W'(16));
      check("wrap.valid", W'(rd_valid), W'(1));
      if (i < 16) check("wrap.old", rd_data, W'('h300) + W'(i));
      else        check("wrap.new", rd_data, W'('h100) + W'(i - 16));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("wrap.ovf", W'(overflow), W'(0));
    drain16("drain_wrap", W'('h104));

    // Empty with write+read together: write accepted, read rejected
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = W'('h55);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("udf.valid", W'(rd_valid),  W'(0));
    check("udf.flag",  W'(underflow), W'(1));
    check("udf.count", W'(count),     W'(1));
    check("udf.hold",  rd_data,       W'('h113));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf.read_valid", W'(rd_valid), W'(1));
    check("udf.read_data",  rd_data,      W'('h55));
    tick();
    check("udf.sticky", W'(underflow), W'(1));

    // 5 words stored, clear beats simultaneous write and read
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = W'('h600) + W'(i);
      tick();
    end
    check("clr.pre_count", W'(count), W'(5));
    rd_en   = 1'b1;
    clear   = 1'b1;
    wr_data = W'('h6FF);
    tick();
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_idle_state("clear2");

    // Async reset mid-write, observed between clock edges
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = W'('h700) + W'(i);
      tick();
    end
    rd_en   = 1'b1;
    wr_data = W'('h703);
    tick();
    check("arst.pre_valid", W'(rd_valid), W'(1));
    check("arst.pre_data",  rd_data,      W'('h700));
    check("arst.pre_count", W'(count),    W'(3));
    #2 reset = 1'b0;
    #1;
    check_idle_state("arst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk) reset = 1'b1;

    // First write after release lands at entry 0 and reads back cleanly
    wr_en   = 1'b1;
    wr_data = W'('h900);
    tick();
    wr_en = 1'b0;
    check("post.count", W'(count), W'(1));
    check("post.entry0", u_dut.r_mem[0], W'('h900));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post.valid", W'(rd_valid), W'(1));
    check("post.data",  rd_data,      W'('h900));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
